usr_lock_regbank: RTL
=====================

Name: usr_lock_regbank

Overview:
Parametrised bank of user-owned registers. Each entry can be claimed (locked) by one user ID, and while locked only its owner, or the privileged ID, may write, read or unlock it. Denied accesses return zero, are flagged per response, and are counted for the security monitor. The bank sits on the configuration bus between user-ID tagged masters and protected datapath settings.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 4, number of entries (≥1, need not be a power of 2).
- ID_W, 2, user ID width.
- PRIV_ID, 2'h2, ID that bypasses ownership checks.
- CNT_W, 8, violation counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe, one request per cycle, no backpressure
- req_op  in  2  0=READ, 1=WRITE, 2=LOCK, 3=UNLOCK
- req_addr  in  clog2(NUM_REGS) (min 1)  entry index
- req_usr_id  in  ID_W  requester ID
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response strobe, exactly 1 cycle after req_valid
- rsp_rdata  out  DATA_W  read data; zero unless the response is an allowed READ
- rsp_denied  out  1  request rejected
- lock_status  out  NUM_REGS  per-entry locked flag
- viol_clr  in  1  clears viol_cnt and viol_sticky
- viol_cnt  out  CNT_W  saturating count of denied requests
- viol_sticky  out  1  set on any denial, held until viol_clr

Behaviour:
- Async reset (rst_n low): all entries data=0, unlocked, owner=0. rsp_valid=0, rsp_rdata=0, rsp_denied=0, viol_cnt=0, viol_sticky=0. Reset mid-request drops the request; no response is produced.
- Per-entry FSM: UNLOCKED -> LOCKED on an allowed LOCK, recording owner=req_usr_id. LOCKED -> UNLOCKED on an allowed UNLOCK.
- Authorisation (auth): entry UNLOCKED, or req_usr_id==owner, or req_usr_id==PRIV_ID.
- READ: if auth, rsp_rdata=data; else rsp_rdata=0 and denied.
- WRITE: if auth, data<=req_wdata, visible to a READ in the next cycle; else data is unchanged and the request is denied.
- LOCK on an UNLOCKED entry: allowed. LOCK on a LOCKED entry: allowed only for the owner (no-op, owner unchanged); PRIV_ID and all others are denied, so PRIV cannot steal ownership.
- UNLOCK: allowed if auth and the entry is LOCKED. UNLOCK of an already-UNLOCKED entry is an allowed no-op.
- Address ≥ NUM_REGS: denied for every op; no state change.
- Response registered: rsp_valid/rsp_rdata/rsp_denied update at the edge after req_valid. They are all 0 in cycles with no request.
- Violation counting:
  - viol_cnt increments by 1 per denied request and saturates at 2^CNT_W-1.
  - viol_sticky sets on any denial.
  - When viol_clr and a denial fall in the same cycle, the clear applies first: viol_cnt=1, viol_sticky=1.
- Back-to-back requests to the same entry see the state updated by the previous request.

Optional Feature:
USR_LOCK_AUDIT_EN:
- Defined: adds outputs audit_usr_id [ID_W], audit_addr [clog2(NUM_REGS)] and audit_op [2]. These capture the most recent denied request at its response edge, reset to 0, and clear on viol_clr unless a denial happens in the same cycle.
- Undefined: these ports and their registers do not exist.

Decomposition:
- Package usr_lock_pkg: op encoding enum (OP_READ/OP_WRITE/OP_LOCK/OP_UNLOCK), entry state enum (ST_UNLOCKED/ST_LOCKED).
- Sub-module usr_lock_entry: one register, its owner and its FSM. Instantiated NUM_REGS times; outputs auth and lock flags to the top, which muxes responses and owns the counter.

Test Plan:
1. Reset, then READ addr0 by id1 -> rsp_valid=1 one cycle later, rdata=0x00, denied=0.
2. id1 LOCK addr1, WRITE 0xA5; id0 WRITE 0x3C to addr1 -> denied=1, viol_cnt=1; id1 READ addr1 -> 0xA5.
3. id0 READ locked addr1 -> rdata=0x00, denied=1. id2 (PRIV) READ -> 0xA5. id2 LOCK addr1 -> denied. id2 UNLOCK -> lock_status[1]=0.
4. 300 denied writes with CNT_W=8 -> viol_cnt=255. viol_clr together with a denial -> viol_cnt=1, sticky=1.
5. NUM_REGS=3, WRITE addr3 -> denied, no entry changes. Assert rst_n low mid-stream -> all outputs 0 immediately.
6. With USR_LOCK_AUDIT_EN: id3 WRITE to locked addr2 -> audit_usr_id=3, audit_addr=2, audit_op=1.

Source files
------------

// File: rtl/usr_lock_pkg.sv
// Shared types for the user-lock register bank: operation and entry-state encodings.
package usr_lock_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_LOCK   = 2'd2,
        OP_UNLOCK = 2'd3
    } op_e;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usr_lock_entry.sv
// One lockable register: data, owner ID and the lock FSM, plus the per-op
// permission decision for a request aimed at this entry.
module usr_lock_entry
    import usr_lock_pkg::*;
#(
    parameter int              DATA_W  = 8,
    parameter int              ID_W    = 2,
    parameter logic [ID_W-1:0] PRIV_ID = ID_W'(2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  op_e               op,
    input  logic [ID_W-1:0]   usr_id,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] data,
    output logic              locked,
    output logic              allow
);

    state_e            state, state_nx;
    logic [ID_W-1:0]   owner;
    logic              is_owner;
    logic              auth;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_UNLOCKED;
            owner <= '0;
            data  <= '0;
        end else begin
            state <= state_nx;
            if (sel && allow) begin
                if (op == OP_WRITE)
                    data <= wdata;
                if (op == OP_LOCK && state == ST_UNLOCKED)
                    owner <= usr_id;
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (sel && allow) begin
            if (op == OP_LOCK)
                state_nx = ST_LOCKED;
            else if (op == OP_UNLOCK)
                state_nx = ST_UNLOCKED;
        end
    end

    // Privileged ID may access and unlock, but may not re-lock someone else's entry.
    always_comb begin
        locked   = (state == ST_LOCKED);
        is_owner = (usr_id == owner);
        auth     = !locked || is_owner || (usr_id == PRIV_ID);
        case (op)
            OP_READ:   allow = auth;
            OP_WRITE:  allow = auth;
            OP_LOCK:   allow = !locked || is_owner;
            OP_UNLOCK: allow = auth;
            default:   allow = 1'b0;
        endcase
    end

endmodule

// File: rtl/usr_lock_regbank.sv
// Bank of user-owned lockable registers with denial counting.
// Optional USR_LOCK_AUDIT_EN adds capture ports for the most recent denied request.
module usr_lock_regbank
    import usr_lock_pkg::*;
#(
    parameter int              DATA_W   = 8,
    parameter int              NUM_REGS = 4,
    parameter int              ID_W     = 2,
    parameter logic [ID_W-1:0] PRIV_ID  = ID_W'(2),
    parameter int              CNT_W    = 8,
    localparam int             ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [ID_W-1:0]     req_usr_id,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_denied,
    output logic [NUM_REGS-1:0] lock_status,
    input  logic                viol_clr,
    output logic [CNT_W-1:0]    viol_cnt,
    output logic                viol_sticky
`ifdef USR_LOCK_AUDIT_EN
    ,
    output logic [ID_W-1:0]     audit_usr_id,
    output logic [ADDR_W-1:0]   audit_addr,
    output logic [1:0]          audit_op
`endif
);

    logic [DATA_W-1:0]   ent_data [NUM_REGS];
    logic [NUM_REGS-1:0] ent_allow;
    logic                sel_allow;
    logic [DATA_W-1:0]   sel_data;
    logic                denied;
    logic [CNT_W-1:0]    cnt_base;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
        usr_lock_entry #(
            .DATA_W  (DATA_W),
            .ID_W    (ID_W),
            .PRIV_ID (PRIV_ID)
        ) u_ent (
            .clk    (clk),
            .rst_n  (rst_n),
            .sel    (req_valid && (req_addr == ADDR_W'(i))),
            .op     (op_e'(req_op)),
            .usr_id (req_usr_id),
            .wdata  (req_wdata),
            .data   (ent_data[i]),
            .locked (lock_status[i]),
            .allow  (ent_allow[i])
        );
    end

    // Out-of-range addresses match no entry, so they fall through as denied.
    always_comb begin
        sel_allow = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (req_addr == ADDR_W'(i)) begin
                sel_allow = ent_allow[i];
                sel_data  = ent_data[i];
            end
        end
        denied   = req_valid && !sel_allow;
        cnt_base = viol_clr ? '0 : viol_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_denied  <= 1'b0;
            viol_cnt    <= '0;
            viol_sticky <= 1'b0;
        end else begin
            rsp_valid   <= req_valid;
            rsp_denied  <= denied;
            rsp_rdata   <= (req_valid && sel_allow && op_e'(req_op) == OP_READ) ? sel_data : '0;
            viol_sticky <= (viol_sticky && !viol_clr) || denied;
            if (denied)
                viol_cnt <= (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
            else
                viol_cnt <= cnt_base;
        end
    end

`ifdef USR_LOCK_AUDIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audit_usr_id <= '0;
            audit_addr   <= '0;
            audit_op     <= '0;
        end else if (denied) begin
            audit_usr_id <= req_usr_id;
            audit_addr   <= req_addr;
            audit_op     <= req_op;
        end else if (viol_clr) begin
            audit_usr_id <= '0;
            audit_addr   <= '0;
            audit_op     <= '0;
        end
    end
`endif

endmodule
